// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data memory controller.
// Used by dmem_ctrl, dmem_wbuf and dmem_ctrl_if.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [DATA_W-1:0] TMO_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        DONE
    } memState_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: req/ack data bus between the controller and memory.
// master = controller side, slave = memory side.
interface dmem_ctrl_if;
    import mem_pkg::*;

    logic              BusReq;
    logic              BusWe;
    logic [ADDR_W-1:0] BusAddr;
    logic [DATA_W-1:0] BusWData;
    logic              BusAck;
    logic [DATA_W-1:0] BusRData;

    modport master (
        output BusReq, BusWe, BusAddr, BusWData,
        input  BusAck, BusRData
    );

    modport slave (
        input  BusReq, BusWe, BusAddr, BusWData,
        output BusAck, BusRData
    );

endinterface

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: single-entry posted write buffer (address + data).
// Only instantiated by dmem_ctrl when DMEM_WBUF_EN is defined.
module dmem_wbuf
    import mem_pkg::*;
(
    input  logic              CLK,
    input  logic              Reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] pushAddr,
    input  logic [DATA_W-1:0] pushData,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (push) begin
            full <= 1'b1;
            addr <= pushAddr;
            data <= pushData;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: M-stage data memory controller running req/ack bus cycles.
// Define DMEM_WBUF_EN to add a 1-entry posted write buffer.
module dmem_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallMem,
    output logic              AlignErr,
    output logic              BusTmo,
    dmem_ctrl_if.master       bus
);

    memState_t         state, stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dataQ;
    logic              reqQ, reqNext;
    logic              weQ, weNext;
    logic [ADDR_W-1:0] addrQ, addrNext;
    logic [DATA_W-1:0] wdataQ, wdataNext;
    logic [ADDR_W-1:0] wordAddr;
    logic              access, misal, waiting, tmoHit;
    logic              stall, alignErr;
    logic              capture, tmoSet, dataClr;

    assign access   = MemReadM | MemWriteM;
    assign misal    = access & (ALUOutM[1:0] != 2'b00);
    assign waiting  = (state == RD_WAIT) | (state == WR_WAIT);
    assign tmoHit   = (cnt == CNT_W'(TIMEOUT - 1));
    assign wordAddr = {ALUOutM[ADDR_W-1:2], 2'b00};

`ifdef DMEM_WBUF_EN
    logic              bufFull, bufPush, bufPop;
    logic              drainQ, drainNext;
    logic [ADDR_W-1:0] bufAddr;
    logic [DATA_W-1:0] bufData;

    dmem_wbuf uWbuf (
        .CLK      (CLK),
        .Reset    (Reset),
        .push     (bufPush),
        .pop      (bufPop),
        .pushAddr (wordAddr),
        .pushData (WriteDataM),
        .full     (bufFull),
        .addr     (bufAddr),
        .data     (bufData)
    );

    // Marks a WR_WAIT that is a background drain, not the M-stage access
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) drainQ <= 1'b0;
        else        drainQ <= drainNext;
    end
`endif

    always_comb begin
        stateNext = state;
        reqNext   = reqQ;
        weNext    = weQ;
        addrNext  = addrQ;
        wdataNext = wdataQ;
        stall     = 1'b0;
        alignErr  = 1'b0;
        capture   = 1'b0;
        tmoSet    = 1'b0;
        dataClr   = 1'b0;
`ifdef DMEM_WBUF_EN
        bufPush   = 1'b0;
        bufPop    = 1'b0;
        drainNext = drainQ;
`endif
        unique case (state)
            IDLE: begin
                alignErr = misal;
`ifdef DMEM_WBUF_EN
                if (bufFull) begin
                    stall     = access & ~misal;
                    reqNext   = 1'b1;
                    weNext    = 1'b1;
                    addrNext  = bufAddr;
                    wdataNext = bufData;
                    drainNext = 1'b1;
                    stateNext = WR_WAIT;
                end else if (!misal && MemWriteM) begin
                    bufPush = 1'b1;
                end else if (!misal && MemReadM) begin
                    stall     = 1'b1;
                    reqNext   = 1'b1;
                    weNext    = 1'b0;
                    addrNext  = wordAddr;
                    stateNext = RD_WAIT;
                end
`else
                if (access && !misal) begin
                    stall     = 1'b1;
                    reqNext   = 1'b1;
                    weNext    = MemWriteM;
                    addrNext  = wordAddr;
                    wdataNext = WriteDataM;
                    stateNext = MemWriteM ? WR_WAIT : RD_WAIT;
                end
`endif
            end
            RD_WAIT, WR_WAIT: begin
                stall = 1'b1;
                if (bus.BusAck || tmoHit) begin
                    reqNext   = 1'b0;
                    tmoSet    = ~bus.BusAck;
                    dataClr   = ~bus.BusAck;
                    capture   = bus.BusAck & (state == RD_WAIT);
                    stateNext = DONE;
                end
`ifdef DMEM_WBUF_EN
                // Drain completion frees the buffer and skips DONE
                if (drainQ) begin
                    stall   = access;
                    dataClr = 1'b0;
                    if (bus.BusAck || tmoHit) begin
                        bufPop    = 1'b1;
                        drainNext = 1'b0;
                        stateNext = IDLE;
                    end
                end
`endif
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            dataQ  <= '0;
            reqQ   <= 1'b0;
            weQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            BusTmo <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= waiting ? cnt + CNT_W'(1) : '0;
            reqQ   <= reqNext;
            weQ    <= weNext;
            addrQ  <= addrNext;
            wdataQ <= wdataNext;
            if (capture)      dataQ <= bus.BusRData;
            else if (dataClr) dataQ <= TMO_DATA;
            if (tmoSet) BusTmo <= 1'b1;
        end
    end

    assign bus.BusReq   = reqQ;
    assign bus.BusWe    = weQ;
    assign bus.BusAddr  = addrQ;
    assign bus.BusWData = wdataQ;

    // Reset also masks the combinational outputs
    assign StallMem  = Reset & stall;
    assign AlignErr  = Reset & alignErr;
    assign ReadDataM = AlignErr ? '0 : dataQ;

endmodule
